// File: rtl/aes_req_packer.sv
// aes_req_packer
//   Gathers a narrow valid/ready word stream (key words, then plaintext words, framed by
//   s_tlast_i) into one 512-bit request beat for the aes_concat core.
//   Beat layout: bytes 0-31 key, bytes 32-47 plaintext, bytes 48-63 zero. Word i of a frame
//   lands at bits [IN_W*i +: IN_W], so bytes appear little-endian in arrival order.
//   Frames that end early are dropped (err_short_o). Frames without tlast on the final word
//   still emit a beat (err_long_o), and the excess words are drained.
//   Optional feature macro: KEY_CACHE_EN. When defined, a frame of exactly the plaintext
//   length reuses the key of the last full frame.
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   s_tvalid_i/s_tready_o   input word handshake; s_tdata_i word, s_tlast_i end of frame
//   m_tvalid_o/m_tready_i   packed request handshake; m_tdata_o packed request
//   err_short_o/err_long_o  single-cycle frame length error pulses
//   frame_cnt_o             number of beats accepted downstream (wraps)
module aes_req_packer #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 512,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic [IN_W-1:0]  s_tdata_i,
  input  logic             s_tlast_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic [OUT_W-1:0] m_tdata_o,
  output logic             err_short_o,
  output logic             err_long_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  localparam int unsigned KW = 256 / IN_W;
  localparam int unsigned PW = 128 / IN_W;
  localparam int unsigned NW = KW + PW;
  localparam int unsigned CW = $clog2(NW + 1);
  localparam int unsigned BW = 384;

  typedef enum logic [1:0] {StCollect, StHold, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    word_cnt_q, word_cnt_d;
  logic [BW-1:0]    buf_q, buf_d;
  logic             drain_q, drain_d;
  logic             rdy_q;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             accept;
  logic             last_word;
  int unsigned      shamt;
  logic [BW-1:0]    wr_mask, wr_word;

`ifdef KEY_CACHE_EN
  logic             key_vld_q, key_vld_d;
  logic [127:0]     side_q, side_d;
  logic [127:0]     side_mask, side_word;
  logic             staging;
`endif

  // rdy_q keeps s_tready_o low during reset and rises on the first clock after release.
  assign s_tready_o  = rdy_q && (state_q != StHold);
  assign m_tvalid_o  = (state_q == StHold);
  assign m_tdata_o   = OUT_W'(buf_q);
  assign err_short_o = err_short_q;
  assign err_long_o  = err_long_q;
  assign frame_cnt_o = frame_cnt_q;

  assign accept    = s_tvalid_i && s_tready_o;
  assign last_word = (word_cnt_q == CW'(NW - 1));
  assign shamt     = IN_W * 32'(word_cnt_q);
  assign wr_mask   = BW'({IN_W{1'b1}}) << shamt;
  assign wr_word   = BW'(s_tdata_i) << shamt;

`ifdef KEY_CACHE_EN
  // While a key is cached, the first PW words are staged so the key survives until the
  // frame length reveals whether this is a plaintext-only frame.
  assign staging   = key_vld_q && (word_cnt_q < CW'(PW));
  assign side_mask = 128'({IN_W{1'b1}}) << shamt;
  assign side_word = 128'(s_tdata_i) << shamt;
`endif

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    buf_d       = buf_q;
    drain_d     = drain_q;
    frame_cnt_d = frame_cnt_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
`ifdef KEY_CACHE_EN
    key_vld_d   = key_vld_q;
    side_d      = side_q;
`endif
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          word_cnt_d = word_cnt_q + CW'(1);
`ifdef KEY_CACHE_EN
          if (staging) side_d = (side_q & ~side_mask) | side_word;
          else         buf_d  = (buf_q & ~wr_mask) | wr_word;
`else
          buf_d = (buf_q & ~wr_mask) | wr_word;
`endif
          if (last_word) begin
            state_d = StHold;
            if (!s_tlast_i) begin
              err_long_d = 1'b1;
              drain_d    = 1'b1;
            end
`ifdef KEY_CACHE_EN
            key_vld_d = 1'b1;
            if (key_vld_q) buf_d[127:0] = side_q;
`endif
          end else if (s_tlast_i) begin
`ifdef KEY_CACHE_EN
            if (key_vld_q && (word_cnt_q == CW'(PW - 1))) begin
              // Plaintext-only frame: cached key stays in buf_q[255:0].
              state_d         = StHold;
              buf_d[383:256]  = side_d;
            end else begin
              err_short_d = 1'b1;
              word_cnt_d  = '0;
              // Once words have reached the key area the cached key is no longer whole.
              if (!staging) begin
                buf_d[255:0] = '0;
                key_vld_d    = 1'b0;
              end
            end
`else
            err_short_d  = 1'b1;
            word_cnt_d   = '0;
            buf_d[255:0] = '0;
`endif
          end
        end
      end
      StHold: begin
        if (m_tready_i) begin
          frame_cnt_d    = frame_cnt_q + CNT_W'(1);
          word_cnt_d     = '0;
          buf_d[383:256] = '0;
          state_d        = drain_q ? StDrain : StCollect;
        end
      end
      StDrain: begin
        if (accept && s_tlast_i) begin
          state_d = StCollect;
          drain_d = 1'b0;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StCollect;
      word_cnt_q  <= '0;
      buf_q       <= '0;
      drain_q     <= 1'b0;
      rdy_q       <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      buf_q       <= buf_d;
      drain_q     <= drain_d;
      rdy_q       <= 1'b1;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef KEY_CACHE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_vld_q <= 1'b0;
      side_q    <= '0;
    end else begin
      key_vld_q <= key_vld_d;
      side_q    <= side_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_packer.sv
// Bench for aes_req_packer (IN_W=32). Frames are modelled as whole word lists: a frame of
// NW or more words yields one beat built from its first NW words, shorter frames are dropped.
module tb_aes_req_packer;
  localparam int IN_W = 32;
  localparam int OUT_W = 512;
  localparam int CNT_W = 16;
  localparam int KW = 256 / IN_W;
  localparam int PW = 128 / IN_W;
  localparam int NW = KW + PW;
`ifdef KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_tvalid, s_tready, s_tlast;
  logic [IN_W-1:0]  s_tdata;
  logic             m_tvalid, m_tready;
  logic [OUT_W-1:0] m_tdata;
  logic             err_short, err_long;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  aes_req_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .s_tdata_i(s_tdata), .s_tlast_i(s_tlast), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .m_tdata_o(m_tdata), .err_short_o(err_short), .err_long_o(err_long),
    .frame_cnt_o(frame_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference state
  logic [31:0]      fw [64];
  logic [383:0]     exp_beats[$];
  logic [383:0]     got_beats[$];
  logic [383:0]     last_beat;
  logic [255:0]     mkey;
  bit               mkey_vld;
  int               exp_short, exp_long, got_short, got_long;
  logic [CNT_W-1:0] exp_fcnt;
  int               cyc = 0;
  int               last_hs_cyc, rise_cyc, first_acc, last_acc;
  bit               rnd_rdy, gaps;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rnd_rdy) m_tready = 1'($urandom_range(0, 1));
  end

  // Monitor: sampled 1 time unit after the falling edge.
  initial begin : monitor
    logic         prev_mv, prev_hs, prev_es, prev_el;
    logic [383:0] prev_data;
    prev_mv = 0; prev_hs = 0; prev_es = 0; prev_el = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (m_tvalid) begin
          check("hold_tready", 384'(s_tready), 384'(0));
          check("pad_zero", 384'(m_tdata[511:384]), 384'(0));
          if (prev_mv && !prev_hs) check("hold_stable", m_tdata[383:0], prev_data);
          if (!prev_mv) rise_cyc = cyc;
          if (m_tready) begin
            got_beats.push_back(m_tdata[383:0]);
            last_hs_cyc = cyc + 1;
          end
        end
        if (err_short) begin
          got_short++;
          check("short_width", 384'(prev_es), 384'(0));
        end
        if (err_long) begin
          got_long++;
          check("long_width", 384'(prev_el), 384'(0));
        end
      end
      prev_mv   = m_tvalid && rst_n;
      prev_hs   = m_tvalid && m_tready;
      prev_data = m_tdata[383:0];
      prev_es   = err_short;
      prev_el   = err_long;
    end
  end

  // Byte b of the frame is byte (b%4) of word b/4.
  function automatic logic [383:0] pack(input int cnt);
    logic [383:0] r;
    r = '0;
    for (int b = 0; b < 4 * cnt; b++) r[8*b +: 8] = fw[b / 4][8*(b % 4) +: 8];
    return r;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic l, output int acc);
    bit done;
    done = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge clk);
      s_tvalid = 0;
    end
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      s_tvalid = 1; s_tdata = d; s_tlast = l;
      if (s_tready) done = 1;
    end
    acc = cyc + 1;
    if (!done) check("accept_timeout", 384'(0), 384'(1));
  endtask

  task automatic send_frame(input int n);
    logic [383:0] full;
    int           a;
    full = pack(NW);
    if (n >= NW) begin
      exp_beats.push_back(full);
      exp_fcnt++;
      if (n > NW) exp_long++;
      mkey = full[255:0];
      mkey_vld = 1;
    end else if (CACHE && mkey_vld && n == PW) begin
      exp_beats.push_back({pack(PW)[127:0], mkey});
      exp_fcnt++;
    end else begin
      exp_short++;
      if (n > PW) mkey_vld = 0;
    end
    for (int i = 0; i < n; i++) begin
      send_word(fw[i], 1'(i == n - 1), a);
      if (i == 0) first_acc = a;
      last_acc = a;
    end
    @(negedge clk);
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic settle();
    bit           ok;
    logic [383:0] e;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (got_beats.size() >= exp_beats.size() && !m_tvalid) ok = 1;
    end
    if (!ok) check("settle_timeout", 384'(0), 384'(1));
    repeat (2) @(negedge clk);
    #2;
    while (exp_beats.size() > 0) begin
      e = exp_beats.pop_front();
      if (got_beats.size() == 0) check("beat_missing", 384'(0), e);
      else begin
        last_beat = got_beats.pop_front();
        check("beat_data", last_beat, e);
      end
    end
    check("extra_beats", 384'(got_beats.size()), 384'(0));
    got_beats.delete();
    check("err_short_cnt", 384'(got_short), 384'(exp_short));
    check("err_long_cnt", 384'(got_long), 384'(exp_long));
    check("frame_cnt", 384'(frame_cnt), 384'(exp_fcnt));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) fw[i] = $urandom;
  endtask

  initial begin
    int a, hs_a, n, r;
    rst_n = 0; s_tvalid = 0; s_tdata = '0; s_tlast = 0; m_tready = 1;
    rnd_rdy = 0; gaps = 0; mkey = '0; mkey_vld = 0; exp_fcnt = '0;
    exp_short = 0; exp_long = 0; got_short = 0; got_long = 0;
    last_hs_cyc = 0; rise_cyc = 0; first_acc = 0; last_acc = 0;
    #1;
    check("rst_tready", 384'(s_tready), 384'(0));
    check("rst_mvalid", 384'(m_tvalid), 384'(0));
    check("rst_mdata", m_tdata[383:0], 384'(0));
    check("rst_fcnt", 384'(frame_cnt), 384'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    check("tready_after_rst", 384'(s_tready), 384'(1));

    // 1: known vector
    for (int i = 0; i < KW; i++)
      fw[i] = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
    for (int i = 0; i < PW; i++)
      fw[KW + i] = {8'((4*i + 3) * 17), 8'((4*i + 2) * 17), 8'((4*i + 1) * 17), 8'(4*i * 17)};
    send_frame(NW);
    settle();
    check("t1_key", 384'(last_beat[255:0]),
          384'(256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100));
    check("t1_pt", 384'(last_beat[383:256]), 384'(128'hffeeddccbbaa99887766554433221100));
    check("t1_latency", 384'(rise_cyc), 384'(last_acc));
    check("t1_fcnt", 384'(frame_cnt), 384'(1));

    // 2: backpressure, next frame waits for the handshake
    m_tready = 0;
    fill_random();
    send_frame(NW);
    fill_random();
    hs_a = 0;
    fork
      begin
        for (int t = 0; t < 100 && !m_tvalid; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        m_tready = 1;
        @(negedge clk);
        #2;
        hs_a = last_hs_cyc;
      end
      send_frame(NW);
    join
    check("t2_resume", 384'(first_acc), 384'(hs_a + 1));
    settle();

    // 3: short frame, then a good frame
    fill_random();
    send_frame(5);
    settle();
    fill_random();
    send_frame(NW);
    settle();

    // 4: long frame, then a clean frame
    fill_random();
    send_frame(NW + 2);
    settle();
    fill_random();
    send_frame(NW);
    settle();

    // 5: full frame, then a plaintext-only length frame
    fill_random();
    send_frame(NW);
    settle();
    fw[0] = 32'he2bec16b; fw[1] = 32'h969f402e; fw[2] = 32'h117e3de9; fw[3] = 32'h2a179373;
    send_frame(PW);
    settle();

    // 6: reset mid-frame
    fill_random();
    for (int i = 0; i < 7; i++) send_word(fw[i], 1'b0, a);
    @(negedge clk);
    s_tvalid = 0;
    rst_n = 0;
    #1;
    check("r6_mvalid", 384'(m_tvalid), 384'(0));
    check("r6_mdata", m_tdata[383:0], 384'(0));
    check("r6_errs", 384'({err_short, err_long}), 384'(0));
    check("r6_fcnt", 384'(frame_cnt), 384'(0));
    check("r6_tready", 384'(s_tready), 384'(0));
    exp_fcnt = '0; mkey_vld = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("r6_tready_rel", 384'(s_tready), 384'(0));
    fill_random();
    send_frame(NW);
    settle();
    check("r6_fcnt_one", 384'(frame_cnt), 384'(1));

    // Random frames with random gaps and backpressure
    gaps = 1;
    rnd_rdy = 1;
    for (int f = 0; f < 30; f++) begin
      fill_random();
      r = $urandom_range(0, 5);
      case (r)
        2:       n = PW;
        3:       n = $urandom_range(1, NW - 1);
        4:       n = NW + $urandom_range(1, 3);
        default: n = NW;
      endcase
      send_frame(n);
      settle();
    end
    rnd_rdy = 0;
    m_tready = 1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
